reg_writeback: RTL and testbench
================================

REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001: Parameter XLEN, default 32, data word width.
REQ-002: Parameter REG_COUNT, default 32, architectural register count; AW = clog2(REG_COUNT).
REQ-003: Parameter STARVE_LIMIT, default 4, maximum consecutive cycles a non-empty load queue may lose arbitration to the ALU.
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst  input  1  reset, synchronous and active-high.
REQ-006: alu_valid_i  input  1  ALU result present this cycle.
REQ-007: alu_ready_o  output  1  ALU result accepted this cycle; ALU holds its result while low.
REQ-008: alu_rd_i  input  AW  ALU destination register.
REQ-009: alu_data_i  input  XLEN  ALU result.
REQ-010: lsu_valid_i  input  1  load result present.
REQ-011: lsu_ready_o  output  1  load queue can accept.
REQ-012: lsu_rd_i  input  AW  load destination register.
REQ-013: lsu_data_i  input  XLEN  load data.
REQ-014: issue_valid_i  input  1  a load is being issued this cycle.
REQ-015: issue_rd_i  input  AW  destination of the issued load.
REQ-016: pending_o  output  REG_COUNT  per-register outstanding-load flag.
REQ-017: write_en_o  output  1  register-file write enable.
REQ-018: write_addr_o  output  AW  register-file write address.
REQ-019: write_data_o  output  XLEN  register-file write data.

Function
REQ-020: Load queue SHALL be a 2-entry FIFO; lsu_ready_o = (count < 2), derived from registered count only; push when lsu_valid_i && lsu_ready_o.
REQ-021: A pushed entry SHALL NOT be eligible for pop in its push cycle (no bypass); first pop no earlier than the following cycle.
REQ-022: Arbitration per cycle: if starve counter == STARVE_LIMIT and queue non-empty, pop queue and drive alu_ready_o = 0; else if alu_valid_i, accept ALU (alu_ready_o = 1); else if queue non-empty, pop queue.
REQ-023: alu_ready_o SHALL be 1 whenever the starvation override is not active, independent of alu_valid_i.
REQ-024: Starve counter SHALL increment (saturating at STARVE_LIMIT) on each cycle the queue is non-empty and the ALU wins; SHALL clear on any queue pop or when the queue is empty.
REQ-025: The selected source's rd/data SHALL be registered into write_addr_o/write_data_o at the edge ending the selection cycle; write_en_o = 1 in the next cycle (1-cycle latency); write_en_o = 0 when nothing is selected.
REQ-026: Results with rd = 0 SHALL be consumed (ALU accepted / queue popped) but write_en_o SHALL be 0 for them.
REQ-027: Simultaneous push and pop with count = 1 SHALL leave count = 1 with correct FIFO order; pointers wrap modulo 2.
REQ-028: pending_o[issue_rd_i] SHALL be set at the edge after issue_valid_i when issue_rd_i != 0; pending_o[0] is constant 0.
REQ-029: pending_o[rd] SHALL be cleared at the edge where a queue entry with that rd is popped; ALU writes SHALL NOT affect pending_o.
REQ-030: If set and clear target the same register in the same cycle, set SHALL win.
REQ-031: Each load SHALL produce exactly one write; queue order equals lsu acceptance order.

Reset
REQ-032: While rst is high at a rising edge: queue count, pointers, starve counter, pending_o SHALL go to 0; write_en_o = 0, write_addr_o = 0, write_data_o = 0.
REQ-033: During reset cycles lsu_ready_o = 1 (count 0) and alu_ready_o = 1 (starve counter 0); inputs presented during reset SHALL be discarded; reset mid-operation drops queued loads without writing them.

Verification
REQ-034: ALU only: alu_valid_i=1, rd=5, data=0xDEADBEEF at cycle N -> cycle N+1 write_en_o=1, addr=5, data=0xDEADBEEF.
REQ-035: Load path: issue rd=7 at N -> pending_o[7]=1 at N+1; load accepted at N+3 with data 0x12345678 and ALU idle -> popped N+4, write_en_o=1 addr=7 at N+5, pending_o[7]=0 at N+5.
REQ-036: Queue full: two loads accepted while ALU valid every cycle -> lsu_ready_o=0 once count=2; third load held until a pop.
REQ-037: Starvation: queue non-empty, ALU valid continuously -> after 4 ALU wins, alu_ready_o=0 for exactly one cycle, load written, ALU result held then written next.
REQ-038: x0 and same-cycle race: ALU rd=0 -> no write; issue rd=9 in same cycle as pop of a load to rd=9 -> pending_o[9] stays 1.
REQ-039: Reset mid-operation: queue holding 2 entries, rst=1 one cycle -> count 0, pending_o=0, no write_en_o pulse for dropped entries.

Source files
------------

// File: rtl/reg_writeback.sv
// Writeback arbiter: ALU results vs. a 2-entry load queue, with starvation guard and pending-load tracking.
// Latency: 1 cycle from selection to write port; backpressure via alu_ready_o / lsu_ready_o.
module reg_writeback #(
    parameter int XLEN         = 32,
    parameter int REG_COUNT    = 32,
    parameter int STARVE_LIMIT = 4,
    localparam int AW          = $clog2(REG_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid_i,
    output logic                 alu_ready_o,
    input  logic [AW-1:0]        alu_rd_i,
    input  logic [XLEN-1:0]      alu_data_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [AW-1:0]        lsu_rd_i,
    input  logic [XLEN-1:0]      lsu_data_i,
    input  logic                 issue_valid_i,
    input  logic [AW-1:0]        issue_rd_i,
    output logic [REG_COUNT-1:0] pending_o,
    output logic                 write_en_o,
    output logic [AW-1:0]        write_addr_o,
    output logic [XLEN-1:0]      write_data_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [1:0]           count_q, count_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        q_rd_q   [2];
    logic [AW-1:0]        q_rd_d   [2];
    logic [XLEN-1:0]      q_data_q [2];
    logic [XLEN-1:0]      q_data_d [2];
    logic [SW-1:0]        starve_q, starve_d;
    logic [REG_COUNT-1:0] pending_q, pending_d;
    logic                 wen_q, wen_d;
    logic [AW-1:0]        waddr_q, waddr_d;
    logic [XLEN-1:0]      wdata_q, wdata_d;

    logic                 q_nonempty, starve_ovr, push, pop, alu_take;
    logic [AW-1:0]        sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic [REG_COUNT-1:0] set_mask, clr_mask;

    always_comb begin
        q_nonempty = (count_q != 2'd0);
        starve_ovr = q_nonempty && (starve_q == SW'(STARVE_LIMIT));
        // Ready depends only on registered state, so an entry pushed this cycle cannot be popped this cycle.
        lsu_ready_o = (count_q < 2'd2);
        alu_ready_o = !starve_ovr;
        push        = lsu_valid_i && lsu_ready_o;
        alu_take    = alu_valid_i && !starve_ovr;
        pop         = q_nonempty && (starve_ovr || !alu_valid_i);

        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        q_rd_d   = q_rd_q;
        q_data_d = q_data_q;
        if (push) begin
            q_rd_d[wr_ptr_q]   = lsu_rd_i;
            q_data_d[wr_ptr_q] = lsu_data_i;
        end

        starve_d = starve_q;
        if (!q_nonempty || pop)
            starve_d = '0;
        else if (alu_take && (starve_q != SW'(STARVE_LIMIT)))
            starve_d = starve_q + SW'(1);

        sel_rd   = alu_rd_i;
        sel_data = alu_data_i;
        if (pop) begin
            sel_rd   = q_rd_q[rd_ptr_q];
            sel_data = q_data_q[rd_ptr_q];
        end
        wen_d   = (pop || alu_take) && (sel_rd != '0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pop || alu_take) begin
            waddr_d = sel_rd;
            wdata_d = sel_data;
        end

        set_mask = '0;
        clr_mask = '0;
        if (issue_valid_i && (issue_rd_i != '0))
            set_mask[issue_rd_i] = 1'b1;
        if (pop)
            clr_mask[q_rd_q[rd_ptr_q]] = 1'b1;
        // Set is applied after clear so a same-cycle reissue keeps the register pending.
        pending_d    = (pending_q & ~clr_mask) | set_mask;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            q_rd_q[0]   <= '0;
            q_rd_q[1]   <= '0;
            q_data_q[0] <= '0;
            q_data_q[1] <= '0;
            starve_q    <= '0;
            pending_q   <= '0;
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            q_rd_q[0]   <= q_rd_d[0];
            q_rd_q[1]   <= q_rd_d[1];
            q_data_q[0] <= q_data_d[0];
            q_data_q[1] <= q_data_d[1];
            starve_q    <= starve_d;
            pending_q   <= pending_d;
            wen_q       <= wen_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign pending_o    = pending_q;
    assign write_en_o   = wen_q;
    assign write_addr_o = waddr_q;
    assign write_data_o = wdata_q;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: reset, ALU path, load path, queue full, starvation, x0/race, mid-run reset.
module tb_reg_writeback;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid_i, alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i, lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] pending_o;
    logic        write_en_o;
    logic [4:0]  write_addr_o;
    logic [31:0] write_data_o;

    int n_checks = 0;
    int n_fail   = 0;

    reg_writeback #(.XLEN(32), .REG_COUNT(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .pending_o(pending_o),
        .write_en_o(write_en_o), .write_addr_o(write_addr_o), .write_data_o(write_data_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0;
        issue_valid_i = 0; issue_rd_i = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h1111;
        lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 32'h2222;
        issue_valid_i = 1; issue_rd_i = 4;
        tick(); tick();
        n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_wen got %b want 0", write_en_o); end
        n_checks++; if (write_addr_o !== 5'd0) begin n_fail++; $display("FAIL rst_addr got %0d want 0", write_addr_o); end
        n_checks++; if (write_data_o !== 32'd0) begin n_fail++; $display("FAIL rst_data got %h want 0", write_data_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL rst_pending got %h want 0", pending_o); end
        n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_lsu_rdy got %b want 1", lsu_ready_o); end
        n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_alu_rdy got %b want 1", alu_ready_o); end
        rst = 0;
        idle_inputs();
        tick(); tick();
        n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_discard_wen got %b want 0", write_en_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL rst_discard_pending got %h want 0", pending_o); end
    endtask

    task automatic test_alu_only();
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'hDEADBEEF;
        n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL alu_rdy got %b want 1", alu_ready_o); end
        tick();
        idle_inputs();
        n_checks++; if (write_en_o !== 1'b1) begin n_fail++; $display("FAIL alu_wen got %b want 1", write_en_o); end
        n_checks++; if (write_addr_o !== 5'd5) begin n_fail++; $display("FAIL alu_addr got %0d want 5", write_addr_o); end
        n_checks++; if (write_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL alu_data got %h want deadbeef", write_data_o); end
        tick();
        n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL alu_idle_wen got %b want 0", write_en_o); end
    endtask

    task automatic test_load_path();
        issue_valid_i = 1; issue_rd_i = 7;
        tick();
        issue_valid_i = 0; issue_rd_i = 0;
        n_checks++; if (pending_o[7] !== 1'b1) begin n_fail++; $display("FAIL ld_pend_set got %b want 1", pending_o[7]); end
        tick();
        tick();
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_data_i = 32'h12345678;
        n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL ld_lsu_rdy got %b want 1", lsu_ready_o); end
        tick();
        idle_inputs();
        n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL ld_nobypass_wen got %b want 0", write_en_o); end
        n_checks++; if (pending_o[7] !== 1'b1) begin n_fail++; $display("FAIL ld_pend_hold got %b want 1", pending_o[7]); end
        tick();
        n_checks++; if (write_en_o !== 1'b1) begin n_fail++; $display("FAIL ld_wen got %b want 1", write_en_o); end
        n_checks++; if (write_addr_o !== 5'd7) begin n_fail++; $display("FAIL ld_addr got %0d want 7", write_addr_o); end
        n_checks++; if (write_data_o !== 32'h12345678) begin n_fail++; $display("FAIL ld_data got %h want 12345678", write_data_o); end
        n_checks++; if (pending_o[7] !== 1'b0) begin n_fail++; $display("FAIL ld_pend_clr got %b want 0", pending_o[7]); end
    endtask

    task automatic test_queue_full();
        alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h100;
        lsu_valid_i = 1; lsu_rd_i = 10; lsu_data_i = 32'hA;
        tick();
        lsu_rd_i = 11; lsu_data_i = 32'hB;
        n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL qf_rdy_c1 got %b want 1", lsu_ready_o); end
        n_checks++; if (write_addr_o !== 5'd1 || write_en_o !== 1'b1) begin n_fail++; $display("FAIL qf_alu_wr got en=%b addr=%0d want en=1 addr=1", write_en_o, write_addr_o); end
        tick();
        lsu_rd_i = 12; lsu_data_i = 32'hC;
        n_checks++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL qf_full_c2 got %b want 0", lsu_ready_o); end
        tick();
        n_checks++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL qf_full_c3 got %b want 0", lsu_ready_o); end
        alu_valid_i = 0;
        tick();
        n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL qf_rdy_after_pop got %b want 1", lsu_ready_o); end
        n_checks++; if (write_addr_o !== 5'd10 || write_data_o !== 32'hA || write_en_o !== 1'b1) begin n_fail++; $display("FAIL qf_wr0 got en=%b addr=%0d data=%h want en=1 addr=10 data=a", write_en_o, write_addr_o, write_data_o); end
        tick();
        lsu_valid_i = 0;
        n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL qf_pushpop_rdy got %b want 1", lsu_ready_o); end
        n_checks++; if (write_addr_o !== 5'd11 || write_data_o !== 32'hB || write_en_o !== 1'b1) begin n_fail++; $display("FAIL qf_wr1 got en=%b addr=%0d data=%h want en=1 addr=11 data=b", write_en_o, write_addr_o, write_data_o); end
        tick();
        n_checks++; if (write_addr_o !== 5'd12 || write_data_o !== 32'hC || write_en_o !== 1'b1) begin n_fail++; $display("FAIL qf_wr2 got en=%b addr=%0d data=%h want en=1 addr=12 data=c", write_en_o, write_addr_o, write_data_o); end
        tick();
        idle_inputs();
        n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL qf_drained_wen got %b want 0", write_en_o); end
    endtask

    task automatic test_starvation();
        alu_valid_i = 1; alu_rd_i = 2; alu_data_i = 32'h200;
        lsu_valid_i = 1; lsu_rd_i = 13; lsu_data_i = 32'hD;
        tick();
        lsu_valid_i = 0;
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL starve_rdy_c%0d got %b want 1", i, alu_ready_o); end
            tick();
        end
        alu_rd_i = 3; alu_data_i = 32'h555;
        n_checks++; if (alu_ready_o !== 1'b0) begin n_fail++; $display("FAIL starve_override got %b want 0", alu_ready_o); end
        n_checks++; if (write_addr_o !== 5'd2 || write_data_o !== 32'h200) begin n_fail++; $display("FAIL starve_alu_wr got addr=%0d data=%h want addr=2 data=200", write_addr_o, write_data_o); end
        tick();
        n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL starve_rdy_back got %b want 1", alu_ready_o); end
        n_checks++; if (write_addr_o !== 5'd13 || write_data_o !== 32'hD || write_en_o !== 1'b1) begin n_fail++; $display("FAIL starve_ld_wr got en=%b addr=%0d data=%h want en=1 addr=13 data=d", write_en_o, write_addr_o, write_data_o); end
        tick();
        idle_inputs();
        n_checks++; if (write_addr_o !== 5'd3 || write_data_o !== 32'h555 || write_en_o !== 1'b1) begin n_fail++; $display("FAIL starve_held_wr got en=%b addr=%0d data=%h want en=1 addr=3 data=555", write_en_o, write_addr_o, write_data_o); end
        tick();
    endtask

    task automatic test_x0_race();
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'hFFFF;
        issue_valid_i = 1; issue_rd_i = 0;
        n_checks++; if (alu_ready_o !== 1'b1) begin n_fail++; $display("FAIL x0_rdy got %b want 1", alu_ready_o); end
        tick();
        idle_inputs();
        n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL x0_wen got %b want 0", write_en_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL x0_pending got %h want 0", pending_o); end
        issue_valid_i = 1; issue_rd_i = 9;
        lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 32'h99;
        tick();
        lsu_valid_i = 0;
        tick();
        issue_valid_i = 0;
        n_checks++; if (pending_o[9] !== 1'b1) begin n_fail++; $display("FAIL race_set_wins got %b want 1", pending_o[9]); end
        n_checks++; if (write_addr_o !== 5'd9 || write_data_o !== 32'h99 || write_en_o !== 1'b1) begin n_fail++; $display("FAIL race_wr got en=%b addr=%0d data=%h want en=1 addr=9 data=99", write_en_o, write_addr_o, write_data_o); end
        tick();
        n_checks++; if (pending_o[9] !== 1'b1) begin n_fail++; $display("FAIL race_pend_stay got %b want 1", pending_o[9]); end
        lsu_valid_i = 1; lsu_rd_i = 9; lsu_data_i = 32'h9A;
        tick();
        lsu_valid_i = 0;
        tick();
        n_checks++; if (pending_o[9] !== 1'b0) begin n_fail++; $display("FAIL race_pend_clr got %b want 0", pending_o[9]); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        alu_valid_i = 1; alu_rd_i = 1; alu_data_i = 32'h1;
        lsu_valid_i = 1; lsu_rd_i = 14; lsu_data_i = 32'hE;
        issue_valid_i = 1; issue_rd_i = 14;
        tick();
        issue_valid_i = 0;
        lsu_rd_i = 15; lsu_data_i = 32'hF;
        tick();
        idle_inputs();
        n_checks++; if (lsu_ready_o !== 1'b0) begin n_fail++; $display("FAIL rm_full got %b want 0", lsu_ready_o); end
        rst = 1;
        tick();
        rst = 0;
        n_checks++; if (lsu_ready_o !== 1'b1) begin n_fail++; $display("FAIL rm_lsu_rdy got %b want 1", lsu_ready_o); end
        n_checks++; if (pending_o !== 32'd0) begin n_fail++; $display("FAIL rm_pending got %h want 0", pending_o); end
        n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL rm_wen0 got %b want 0", write_en_o); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (write_en_o !== 1'b0) begin n_fail++; $display("FAIL rm_wen%0d got %b want 0", i, write_en_o); end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_alu_only();
        test_load_path();
        test_queue_full();
        test_starvation();
        test_x0_race();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
